reg_pipe_chain: RTL and testbench
=================================

// Module: reg_pipe_chain
// PURPOSE
//   Parametrised operand pipeline for the DSP48A1 datapath, generalising the single
//   optional register into a DEPTH-stage chain with per-stage valid tracking.
//   Uses a valid/ready handshake, collapses bubbles and supports a synchronous flush.
//   Sits between the operand input ports and the pre-adder/multiplier. DEPTH=0 is a pure wire.
// PARAMETERS
//   DATA_WIDTH  18  payload width in bits (1..48)
//   DEPTH       2   number of register stages (0..8); 0 = combinational pass-through
//   RST_VAL     0   value loaded into every stage data register on reset
// PORTS
//   CLK        in   1           clock; all state updates on the rising edge
//   RST        in   1           asynchronous, active-high reset
//   CE         in   1           clock enable; gates all data/valid advancement
//   FLUSH      in   1           synchronous clear of all stage valids
//   IN_VALID   in   1           upstream word valid
//   IN_READY   out  1           chain accepts D this cycle
//   D          in   DATA_WIDTH  input payload
//   OUT_VALID  out  1           last stage holds a valid word
//   OUT_READY  in   1           downstream accepts Q this cycle
//   Q          out  DATA_WIDTH  output payload (last stage data)
//   OCC        out  $clog2(DEPTH+1)  number of valid stages (REG_PIPE_OCC_EN only)
// BEHAVIOUR
//   - Reset (async assert, sync release): all stage valids 0, all data RST_VAL.
//     Hence OUT_VALID=0, Q=RST_VAL, OCC=0; IN_READY follows CE (chain empty).
//   - Stage k "can accept" = !valid[k] | advance[k].
//     advance[DEPTH-1] = OUT_READY. advance[k] = valid[k] & accept[k+1].
//   - IN_READY = CE & accept[0]. This is combinational through the chain; there is no skid.
//   - On an edge with CE=1, stage k loads from stage k-1 (stage 0 loads from D/IN_VALID)
//     when accept[k]. It sets valid[k] = valid[k-1] of the source.
//     Data registers load only when the source is valid; otherwise they hold.
//   - CE=0: no stage changes, IN_READY=0. OUT_VALID/Q are held and remain visible.
//   - Bubble collapsing: an invalid stage always accepts, even when OUT_READY=0.
//     DEPTH words can be held with the output stalled.
//   - Latency: DEPTH cycles from IN_VALID&IN_READY to OUT_VALID with no stalls.
//     Throughput is 1 word/cycle.
//   - Simultaneous accept at input and drain at output in one edge: OCC unchanged.
//   - Full chain (OCC=DEPTH) with OUT_READY=0: IN_READY=0, contents frozen.
//   - FLUSH=1 at an edge: all valids cleared regardless of CE, IN_VALID or OUT_READY.
//     The incoming word that edge is discarded; data registers hold; OCC=0 next cycle.
//     IN_READY is forced 0 while FLUSH=1.
//   - RST mid-stream: immediate clear of all state; in-flight words are lost, not drained.
//   - DEPTH=0: Q=D, OUT_VALID=IN_VALID&CE&!FLUSH, IN_READY=OUT_READY&CE&!FLUSH, OCC=0.
//   - Order preserved; no word duplicated or dropped except by FLUSH or RST.
// CONFIGURATION
//   REG_PIPE_OCC_EN defined: OCC port present. It is a registered popcount of the stage
//     valids, updated each edge: +1 on input accept, -1 on output drain, both = no change.
//   REG_PIPE_OCC_EN undefined: OCC port and its counter are absent; all other behaviour is identical.
// STRUCTURE
//   Package reg_pipe_pkg: REG_PIPE_MAX_DEPTH=8, clog2 function,
//   occupancy width constant and RST_VAL default.
//   Sub-module reg_pipe_slot: one stage (data register, valid flag, accept/advance logic)
//   with the same CLK/RST/CE/FLUSH semantics. reg_pipe_chain instantiates DEPTH slots
//   in a generate loop and adds the DEPTH=0 wire path plus the optional OCC counter.
// TESTING
//   1. DEPTH=3, OUT_READY=1, stream D=1,2,3,4 one per cycle
//      -> Q=1 with OUT_VALID at cycle 3, then 2,3,4 consecutively, OCC=3 steady.
//   2. DEPTH=3, OUT_READY=0, push 5,6,7,8 -> 5,6,7 accepted, IN_READY=0 on 8, OCC=3.
//      Release OUT_READY -> 5,6,7 then 8 emitted in order.
//   3. DEPTH=3, one word A=0x2AAAA then idle with OUT_READY=0 -> A reaches the last stage.
//      Push B,C -> both accepted (bubbles collapse), OCC=3.
//   4. DEPTH=2, CE=0 for 4 cycles mid-stream -> Q/OUT_VALID frozen, IN_READY=0.
//      CE=1 -> stream resumes with no loss or duplication.
//   5. DEPTH=3, full chain, FLUSH=1 with IN_VALID=1 for one edge -> OUT_VALID=0, OCC=0 next cycle.
//      Next pushed word exits after 3 cycles.
//   6. DEPTH=4, RST pulse between clock edges while OCC=2 -> OUT_VALID=0, Q=RST_VAL, OCC=0 immediately.
//      DEPTH=0 sweep: Q==D, IN_READY==OUT_READY.

Source files
------------

// File: rtl/reg_pipe_chain_pkg.sv
// Shared constants and helpers for the reg_pipe_chain operand pipeline.
package reg_pipe_pkg;

  localparam int unsigned REG_PIPE_MAX_DEPTH = 8;
  localparam int unsigned REG_PIPE_DEF_WIDTH = 18;
  localparam logic [47:0] REG_PIPE_RST_VAL   = '0;

  // Ceiling log2; returns 0 for values 0 and 1.
  function automatic int unsigned reg_pipe_clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) width = i + 1;
    end
    return width;
  endfunction

  // Occupancy counter width for a given depth, never narrower than one bit.
  function automatic int unsigned reg_pipe_occ_w(input int unsigned depth);
    int unsigned w;
    w = reg_pipe_clog2(depth + 1);
    return (w == 0) ? 1 : w;
  endfunction

  localparam int unsigned REG_PIPE_OCC_W_MAX = reg_pipe_occ_w(REG_PIPE_MAX_DEPTH);

endpackage

// File: rtl/reg_pipe_chain_if.sv
// Handshake bundle for reg_pipe_chain: upstream valid/ready/data, downstream
// valid/ready/data and, with REG_PIPE_OCC_EN defined, the occupancy count.
interface reg_pipe_chain_if
  import reg_pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = REG_PIPE_DEF_WIDTH,
  parameter int unsigned DEPTH      = 2
) ();

  logic                  IN_VALID;
  logic                  IN_READY;
  logic [DATA_WIDTH-1:0] D;
  logic                  OUT_VALID;
  logic                  OUT_READY;
  logic [DATA_WIDTH-1:0] Q;
`ifdef REG_PIPE_OCC_EN
  localparam int unsigned OCC_W = reg_pipe_occ_w(DEPTH);
  logic [OCC_W-1:0]      OCC;
`endif

  modport master (
    output IN_VALID, D, OUT_READY,
    input  IN_READY, OUT_VALID, Q
`ifdef REG_PIPE_OCC_EN
    , input OCC
`endif
  );

  modport slave (
    input  IN_VALID, D, OUT_READY,
    output IN_READY, OUT_VALID, Q
`ifdef REG_PIPE_OCC_EN
    , output OCC
`endif
  );

endinterface

// File: rtl/reg_pipe_chain_slot.sv
// One pipeline stage: data register, valid flag and accept/advance logic.
module reg_pipe_slot
  import reg_pipe_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = REG_PIPE_DEF_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = REG_PIPE_RST_VAL[DATA_WIDTH-1:0]
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CE,
  input  logic                  FLUSH,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic                  down_accept,
  output logic                  accept,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data
);

  logic advance;

  // An empty stage always accepts, which is what collapses bubbles.
  assign advance = valid & down_accept;
  assign accept  = ~valid | advance;

  // Stage state: flush clears valid only; data loads only from a valid source.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid <= 1'b0;
      data  <= RST_VAL;
    end else if (FLUSH) begin
      valid <= 1'b0;
    end else if (CE && accept) begin
      valid <= src_valid;
      if (src_valid) data <= src_data;
    end
  end

endmodule

// File: rtl/reg_pipe_chain.sv
// reg_pipe_chain: DEPTH-stage valid/ready operand pipeline with bubble
// collapsing, clock enable and synchronous flush. DEPTH=0 is a wire.
// Optional feature macro: REG_PIPE_OCC_EN adds the OCC occupancy port.
module reg_pipe_chain
  import reg_pipe_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = REG_PIPE_DEF_WIDTH,
  parameter int unsigned           DEPTH      = 2,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = REG_PIPE_RST_VAL[DATA_WIDTH-1:0]
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CE,
  input  logic            FLUSH,
  reg_pipe_chain_if.slave bus
);

  if (DEPTH == 0) begin : g_wire
    assign bus.Q         = bus.D;
    assign bus.OUT_VALID = bus.IN_VALID & CE & ~FLUSH;
    assign bus.IN_READY  = bus.OUT_READY & CE & ~FLUSH;
  end else begin : g_chain
    logic [DEPTH-1:0]      stage_valid;
    logic [DEPTH-1:0]      stage_accept;
    logic [DATA_WIDTH-1:0] stage_data [DEPTH];

    // Accept ripples combinationally from the output back to the input.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic                  src_valid;
      logic [DATA_WIDTH-1:0] src_data;
      logic                  down_accept;

      if (k == 0) begin : g_head
        assign src_valid = bus.IN_VALID;
        assign src_data  = bus.D;
      end else begin : g_body
        assign src_valid = stage_valid[k-1];
        assign src_data  = stage_data[k-1];
      end

      if (k == DEPTH - 1) begin : g_tail
        assign down_accept = bus.OUT_READY;
      end else begin : g_link
        assign down_accept = stage_accept[k+1];
      end

      reg_pipe_slot #(
        .DATA_WIDTH (DATA_WIDTH),
        .RST_VAL    (RST_VAL)
      ) u_slot (
        .CLK         (CLK),
        .RST         (RST),
        .CE          (CE),
        .FLUSH       (FLUSH),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .down_accept (down_accept),
        .accept      (stage_accept[k]),
        .valid       (stage_valid[k]),
        .data        (stage_data[k])
      );
    end

    assign bus.IN_READY  = CE & ~FLUSH & stage_accept[0];
    assign bus.OUT_VALID = stage_valid[DEPTH-1];
    assign bus.Q         = stage_data[DEPTH-1];
  end

`ifdef REG_PIPE_OCC_EN
  localparam int unsigned OCC_W = reg_pipe_occ_w(DEPTH);

  if (DEPTH == 0) begin : g_occ_none
    assign bus.OCC = '0;
  end else begin : g_occ
    logic             in_fire;
    logic             out_fire;
    logic [OCC_W-1:0] occ_q;

    assign in_fire  = bus.IN_VALID & bus.IN_READY;
    assign out_fire = CE & bus.OUT_VALID & bus.OUT_READY;

    // Running count of valid stages; a simultaneous fill and drain cancel out.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        occ_q <= '0;
      end else if (FLUSH) begin
        occ_q <= '0;
      end else if (in_fire && !out_fire) begin
        occ_q <= occ_q + OCC_W'(1);
      end else if (out_fire && !in_fire) begin
        occ_q <= occ_q - OCC_W'(1);
      end
    end

    assign bus.OCC = occ_q;
  end
`endif

endmodule

// File: tb/tb_reg_pipe_chain.sv
// Self-checking bench for reg_pipe_chain: four instances (DEPTH 3, 2, 4, 0)
// share one stimulus stream and are compared each cycle against a positional
// word-list model. OCC is checked when REG_PIPE_OCC_EN is defined.
module tb_reg_pipe_chain;
  import reg_pipe_pkg::*;

  localparam int unsigned W    = 18;
  localparam int          NDUT = 4;
  localparam int          MAXW = 9;

  function automatic int dep_of(input int g);
    case (g)
      0:       return 3;
      1:       return 2;
      2:       return 4;
      default: return 0;
    endcase
  endfunction

  logic         CLK = 1'b0;
  logic         RST, CE, FLUSH, iv, ordy;
  logic [W-1:0] din;

  always #5 CLK = ~CLK;

  logic         ir [NDUT];
  logic         ov [NDUT];
  logic [W-1:0] q  [NDUT];
`ifdef REG_PIPE_OCC_EN
  logic [31:0]  occ [NDUT];
`endif

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned GD = dep_of(g);

    reg_pipe_chain_if #(.DATA_WIDTH(W), .DEPTH(GD)) bus ();

    reg_pipe_chain #(
      .DATA_WIDTH (W),
      .DEPTH      (GD),
      .RST_VAL    ('0)
    ) dut (
      .CLK   (CLK),
      .RST   (RST),
      .CE    (CE),
      .FLUSH (FLUSH),
      .bus   (bus.slave)
    );

    assign bus.IN_VALID  = iv;
    assign bus.D         = din;
    assign bus.OUT_READY = ordy;
    assign ir[g]         = bus.IN_READY;
    assign ov[g]         = bus.OUT_VALID;
    assign q[g]          = bus.Q;
`ifdef REG_PIPE_OCC_EN
    assign occ[g]        = 32'(bus.OCC);
`endif
  end

  // Model: ordered word list (head first) with the stage index each word sits in.
  int           mcnt [NDUT];
  int           mpos [NDUT][MAXW];
  logic [W-1:0] mdat [NDUT][MAXW];
  logic [W-1:0] mq   [NDUT];
  int           ncnt [NDUT];
  int           npos [NDUT][MAXW];
  logic [W-1:0] ndat [NDUT][MAXW];
  logic [W-1:0] nq   [NDUT];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < NDUT; g++) begin
      mcnt[g] = 0;
      mq[g]   = '0;
    end
  endtask

  // Each word moves one stage forward unless the word ahead of it ends the
  // cycle directly in front; the head leaves when it is in the last stage and
  // the output is ready. A new word enters stage 0 if that stage ends up free.
  task automatic model_step(input int g, output logic rdy);
    int n, lim, j, np;
    n       = dep_of(g);
    ncnt[g] = 0;
    nq[g]   = mq[g];
    rdy     = 1'b0;
    if (n == 0) begin
      rdy = ordy & CE & ~FLUSH;
    end else if (FLUSH) begin
      rdy = 1'b0;
    end else if (!CE) begin
      for (int k = 0; k < mcnt[g]; k++) begin
        npos[g][k] = mpos[g][k];
        ndat[g][k] = mdat[g][k];
      end
      ncnt[g] = mcnt[g];
    end else begin
      lim = n;
      j   = 0;
      for (int k = 0; k < mcnt[g]; k++) begin
        if (!(k == 0 && mpos[g][0] == n - 1 && ordy)) begin
          np = mpos[g][k] + 1;
          if (np > lim - 1) np = lim - 1;
          npos[g][j] = np;
          ndat[g][j] = mdat[g][k];
          j++;
          lim = np;
        end
      end
      rdy = (lim >= 1);
      if (rdy && iv) begin
        npos[g][j] = 0;
        ndat[g][j] = din;
        j++;
      end
      ncnt[g] = j;
      if (j > 0 && npos[g][0] == n - 1) nq[g] = ndat[g][0];
    end
  endtask

  task automatic model_commit();
    for (int g = 0; g < NDUT; g++) begin
      mcnt[g] = ncnt[g];
      mq[g]   = nq[g];
      for (int k = 0; k < ncnt[g]; k++) begin
        mpos[g][k] = npos[g][k];
        mdat[g][k] = ndat[g][k];
      end
    end
  endtask

  // One clock: check outputs at the falling edge, then advance the model.
  task automatic cyc();
    logic rdy;
    int   n;
    @(negedge CLK);
    for (int g = 0; g < NDUT; g++) begin
      n = dep_of(g);
      model_step(g, rdy);
      check_eq($sformatf("d%0d_in_ready", n), 32'(ir[g]), 32'(rdy));
      if (n == 0) begin
        check_eq("d0_out_valid", 32'(ov[g]), 32'(iv & CE & ~FLUSH));
        check_eq("d0_q", 32'(q[g]), 32'(din));
      end else begin
        check_eq($sformatf("d%0d_out_valid", n), 32'(ov[g]),
                 32'(mcnt[g] > 0 && mpos[g][0] == n - 1));
        check_eq($sformatf("d%0d_q", n), 32'(q[g]), 32'(mq[g]));
`ifdef REG_PIPE_OCC_EN
        check_eq($sformatf("d%0d_occ", n), occ[g], 32'(mcnt[g]));
`endif
      end
    end
    @(posedge CLK);
    #1;
    if (RST) model_reset();
    else     model_commit();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; CE = 1'b0; FLUSH = 1'b0; iv = 1'b0; ordy = 1'b0; din = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst_ov", 32'(ov[0]), 32'd0);
    check_eq("rst_q", 32'(q[0]), 32'd0);
    RST = 1'b0;
    CE  = 1'b1;

    // Streaming with the output always ready.
    ordy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      iv  = 1'b1;
      din = W'(i);
      cyc();
      if (i == 3) begin
        check_eq("s1_first_ov", 32'(ov[0]), 32'd1);
        check_eq("s1_first_q", 32'(q[0]), 32'd1);
      end
    end
`ifdef REG_PIPE_OCC_EN
    check_eq("s1_occ", occ[0], 32'd3);
`endif
    iv = 1'b0;
    repeat (5) cyc();

    // Output stalled: chain fills, then drains in order.
    ordy = 1'b0;
    for (int i = 5; i <= 8; i++) begin
      iv  = 1'b1;
      din = W'(i);
      cyc();
      if (i == 7) check_eq("s2_full_rdy", 32'(ir[0]), 32'd0);
    end
    iv   = 1'b0;
    ordy = 1'b1;
    repeat (6) cyc();

    // Single word runs to the last stage, later words collapse the bubbles.
    ordy = 1'b0;
    iv   = 1'b1;
    din  = 18'h2AAAA;
    cyc();
    iv = 1'b0;
    repeat (3) cyc();
    check_eq("s3_head_ov", 32'(ov[0]), 32'd1);
    check_eq("s3_head_q", 32'(q[0]), 32'h2AAAA);
    iv  = 1'b1;
    din = 18'h01111;
    cyc();
    din = 18'h02222;
    cyc();
    iv = 1'b0;
`ifdef REG_PIPE_OCC_EN
    check_eq("s3_occ", occ[0], 32'd3);
`endif
    ordy = 1'b1;
    repeat (6) cyc();

    // Clock enable held low mid-stream.
    iv = 1'b1;
    for (int i = 0; i < 11; i++) begin
      CE  = !(i >= 3 && i < 7);
      din = W'(100 + i);
      cyc();
    end
    CE = 1'b1;
    iv = 1'b0;
    repeat (6) cyc();

    // Flush a full chain while a word is offered.
    ordy = 1'b0;
    iv   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = W'(200 + i);
      cyc();
    end
    FLUSH = 1'b1;
    din   = W'(250);
    cyc();
    FLUSH = 1'b0;
    iv    = 1'b0;
    check_eq("s5_flush_ov", 32'(ov[0]), 32'd0);
`ifdef REG_PIPE_OCC_EN
    check_eq("s5_flush_occ", occ[0], 32'd0);
`endif
    iv  = 1'b1;
    din = 18'h03333;
    cyc();
    iv   = 1'b0;
    ordy = 1'b1;
    repeat (2) cyc();
    check_eq("s5_next_ov", 32'(ov[0]), 32'd1);
    check_eq("s5_next_q", 32'(q[0]), 32'h03333);
    repeat (3) cyc();

    // Asynchronous reset between edges with two words in flight.
    ordy = 1'b0;
    iv   = 1'b1;
    din  = W'(300);
    cyc();
    din = W'(301);
    cyc();
    iv = 1'b0;
    #1 RST = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      check_eq($sformatf("s6_rst_ov_d%0d", dep_of(g)), 32'(ov[g]), 32'd0);
      check_eq($sformatf("s6_rst_q_d%0d", dep_of(g)), 32'(q[g]), 32'd0);
`ifdef REG_PIPE_OCC_EN
      check_eq($sformatf("s6_rst_occ_d%0d", dep_of(g)), occ[g], 32'd0);
`endif
    end
    model_reset();
    #1 RST = 1'b0;
    ordy = 1'b1;
    repeat (2) cyc();

    // Randomised traffic across all depths.
    for (int i = 0; i < 3000; i++) begin
      iv    = ($urandom_range(0, 9) < 7);
      ordy  = ($urandom_range(0, 9) < 6);
      CE    = ($urandom_range(0, 9) < 9);
      FLUSH = ($urandom_range(0, 99) < 3);
      din   = W'($urandom);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
